// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: FSM states, port IDs
// and default address/data widths.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner select.
// Ports: i_p0_req, i_p1_req, i_last_grant in;
//        o_grant out (PORT_CPU / PORT_AUX).
// Macro DMEM_ARB_ROUND_ROBIN_EN: ties alternate,
// otherwise port 0 always wins a tie.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic i_p0_req,
  input  logic i_p1_req,
  input  logic i_last_grant,
  output logic o_grant
);

  logic w_tie;
  logic w_p1_only;

  assign w_tie     = i_p0_req & i_p1_req;
  assign w_p1_only = ~i_p0_req & i_p1_req;

  always_comb begin
    o_grant = PORT_CPU;
    unique case (1'b1)
      w_tie: begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        o_grant = ~i_last_grant;
`else
        o_grant = PORT_CPU;
`endif
      end
      w_p1_only: o_grant = PORT_AUX;
      default:   o_grant = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter/sequencer for a
// single-port DataMemory (IDLE -> ACCESS -> RESP).
// Ports: clk, rst (async high); p0_*/p1_* req, we,
// addr, wdata in, ack, rdata out; mem_* drive and
// mem_ReadData in; busy out.
// Macro DMEM_ARB_ROUND_ROBIN_EN selects tie policy.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_Address,
  output logic [DATA_W-1:0] mem_WriteData,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [DATA_W-1:0] mem_ReadData,
  output logic              busy
);

  state_t            r_state;
  logic              r_last_grant;
  logic              r_sel;
  logic              r_p0_ack;
  logic              r_p1_ack;
  logic [DATA_W-1:0] r_p0_rdata;
  logic [DATA_W-1:0] r_p1_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic              r_mem_re;

  logic              w_any;
  logic              w_grant;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  dmem_arb_pick u_pick (
    .i_p0_req     (p0_req),
    .i_p1_req     (p1_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_any   = p0_req | p1_req;
  assign w_we    = w_grant ? p1_we    : p0_we;
  assign w_addr  = w_grant ? p1_addr  : p0_addr;
  assign w_wdata = w_grant ? p1_wdata : p0_wdata;

  // Memory drive regs double as the payload latch:
  // loaded entering ACCESS, cleared leaving it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= PORT_AUX;
      r_sel        <= PORT_CPU;
      r_p0_ack     <= 1'b0;
      r_p1_ack     <= 1'b0;
      r_p0_rdata   <= '0;
      r_p1_rdata   <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
    end else begin
      r_p0_ack <= 1'b0;
      r_p1_ack <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel        <= w_grant;
            r_last_grant <= w_grant;
            r_mem_addr   <= w_addr;
            r_mem_wdata  <= w_wdata;
            r_mem_we     <= w_we;
            r_mem_re     <= ~w_we;
            r_state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_mem_re) begin
            if (r_sel == PORT_CPU)
              r_p0_rdata <= mem_ReadData;
            else
              r_p1_rdata <= mem_ReadData;
          end
          r_p0_ack    <= (r_sel == PORT_CPU);
          r_p1_ack    <= (r_sel == PORT_AUX);
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          r_mem_we    <= 1'b0;
          r_mem_re    <= 1'b0;
          r_state     <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign p0_ack        = r_p0_ack;
  assign p1_ack        = r_p1_ack;
  assign p0_rdata      = r_p0_rdata;
  assign p1_rdata      = r_p1_rdata;
  assign mem_Address   = r_mem_addr;
  assign mem_WriteData = r_mem_wdata;
  assign mem_MemWrite  = r_mem_we;
  assign mem_MemRead   = r_mem_re;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random + directed bench against
// a transaction-level arbitration/memory model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req [2];
  logic        we  [2];
  logic [31:0] addr[2];
  logic [31:0] wd  [2];

  logic        p0_ack, p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_Address, mem_WriteData;
  logic [31:0] mem_ReadData;
  logic        mem_MemWrite, mem_MemRead, busy;

  dmem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .p0_req        (req[0]),
    .p0_we         (we[0]),
    .p0_addr       (addr[0]),
    .p0_wdata      (wd[0]),
    .p0_ack        (p0_ack),
    .p0_rdata      (p0_rdata),
    .p1_req        (req[1]),
    .p1_we         (we[1]),
    .p1_addr       (addr[1]),
    .p1_wdata      (wd[1]),
    .p1_ack        (p1_ack),
    .p1_rdata      (p1_rdata),
    .mem_Address   (mem_Address),
    .mem_WriteData (mem_WriteData),
    .mem_MemWrite  (mem_MemWrite),
    .mem_MemRead   (mem_MemRead),
    .mem_ReadData  (mem_ReadData),
    .busy          (busy)
  );

  // DataMemory stand-in: comb read, write at edge
  logic [31:0] mem[16];
  assign mem_ReadData = mem[mem_Address[5:2]];
  always @(posedge clk)
    if (mem_MemWrite)
      mem[mem_Address[5:2]] <= mem_WriteData;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  typedef struct {
    int          p;
    int          c;
    logic [31:0] d;
  } ev_t;

  txn_t        tq[2][4];
  int          tn[2];
  int          toff[2];
  ev_t         obs[$];
  ev_t         expq[$];
  logic [31:0] ref_mem[16];
  logic [31:0] ref_rd[2];
  logic        ref_last;
  int          n_chk = 0;
  int          n_err = 0;
  int          w_cnt, r_cnt, exp_w, exp_r;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("strb_excl",
            {63'b0, mem_MemWrite & mem_MemRead}, 0);
      if (!mem_MemWrite && !mem_MemRead) begin
        check("idle_addr", {32'b0, mem_Address}, 0);
        check("idle_wd", {32'b0, mem_WriteData}, 0);
      end else begin
        check("busy_acc", {63'b0, busy}, 1);
      end
      if (mem_MemWrite) w_cnt++;
      if (mem_MemRead) r_cnt++;
    end
  end

  task automatic clr();
    tn   = '{0, 0};
    toff = '{0, 0};
  endtask

  task automatic add(input int p, input logic w,
                     input logic [31:0] a,
                     input logic [31:0] d);
    tq[p][tn[p]] = '{w, a, d};
    tn[p]++;
  endtask

  task automatic put(input int p, input int i);
    we[p]   = tq[p][i].we;
    addr[p] = tq[p][i].a;
    wd[p]   = tq[p][i].d;
  endtask

  // Transaction-level model: one grant per 3 edges,
  // ack one edge after the grant edge.
  task automatic build_exp(input int base);
    int   rdy[2];
    int   ix[2];
    int   fr, e, w;
    bit   c0, c1;
    txn_t t;
    ev_t  ev;
    fr = base;
    ix = '{0, 0};
    rdy[0] = base + toff[0];
    rdy[1] = base + toff[1];
    while (ix[0] < tn[0] || ix[1] < tn[1]) begin
      e = 1 << 30;
      for (int p = 0; p < 2; p++)
        if (ix[p] < tn[p] && rdy[p] < e) e = rdy[p];
      if (e < fr) e = fr;
      c0 = (ix[0] < tn[0]) && (rdy[0] <= e);
      c1 = (ix[1] < tn[1]) && (rdy[1] <= e);
      if (c0 && c1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        w = ref_last ? 0 : 1;
`else
        w = 0;
`endif
      end else begin
        w = c1 ? 1 : 0;
      end
      t = tq[w][ix[w]];
      if (t.we) begin
        ref_mem[t.a[5:2]] = t.d;
        exp_w++;
      end else begin
        ref_rd[w] = ref_mem[t.a[5:2]];
        exp_r++;
      end
      ev.p = w;
      ev.c = e + 1;
      ev.d = ref_rd[w];
      expq.push_back(ev);
      ref_last = (w == 1);
      rdy[w]   = e + 2;
      fr       = e + 3;
      ix[w]++;
    end
  endtask

  task automatic drv(input int p);
    int  idx = 0;
    int  to  = 0;
    bit  a;
    ev_t ev;
    if (tn[p] == 0) return;
    repeat (toff[p]) @(negedge clk);
    put(p, 0);
    req[p] = 1'b1;
    while (idx < tn[p]) begin
      @(posedge clk);
      #1;
      a = (p == 0) ? p0_ack : p1_ack;
      if (a) begin
        ev.p = p;
        ev.c = cyc;
        ev.d = (p == 0) ? p0_rdata : p1_rdata;
        obs.push_back(ev);
        idx++;
        to = 0;
        if (idx < tn[p]) put(p, idx);
        else req[p] = 1'b0;
      end else begin
        to++;
        if (to > 40) begin
          check("ack_timeout", 1, 0);
          req[p] = 1'b0;
          idx = tn[p];
        end
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    @(negedge clk);
    while (busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, {63'b0, busy}, 0);
  endtask

  task automatic run_scn(input string tag);
    int base, n;
    wait_idle(tag);
    obs.delete();
    expq.delete();
    exp_w = 0; exp_r = 0;
    w_cnt = 0; r_cnt = 0;
    base = cyc + 1;
    build_exp(base);
    fork
      drv(0);
      drv(1);
    join
    @(negedge clk);
    check({tag, "_n"}, obs.size(), expq.size());
    n = (obs.size() < expq.size()) ?
        obs.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_p%0d", tag, i),
            obs[i].p, expq[i].p);
      check($sformatf("%s_c%0d", tag, i),
            obs[i].c, expq[i].c);
      check($sformatf("%s_d%0d", tag, i),
            {32'b0, obs[i].d}, {32'b0, expq[i].d});
    end
    check({tag, "_wcnt"}, w_cnt, exp_w);
    check({tag, "_rcnt"}, r_cnt, exp_r);
    for (int i = 0; i < 16; i++)
      if (mem[i] !== ref_mem[i])
        check($sformatf("%s_mem%0d", tag, i),
              {32'b0, mem[i]}, {32'b0, ref_mem[i]});
  endtask

  task automatic rst_test();
    logic [31:0] old;
    wait_idle("ra");
    old     = mem[2];
    we[1]   = 1'b1;
    addr[1] = 32'h8;
    wd[1]   = ~old;
    req[1]  = 1'b1;
    @(posedge clk);
    #1;
    check("ra_wr", {63'b0, mem_MemWrite}, 1);
    #1 rst = 1'b1;
    #1;
    check("ra_strb",
          {62'b0, mem_MemWrite, mem_MemRead}, 0);
    check("ra_busy", {63'b0, busy}, 0);
    check("ra_addr", {32'b0, mem_Address}, 0);
    req[1] = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("ra_noack", {63'b0, p1_ack}, 0);
    end
    check("ra_mem", {32'b0, mem[2]}, {32'b0, old});
    check("ra_rd0", {32'b0, p0_rdata}, 0);
    check("ra_rd1", {32'b0, p1_rdata}, 0);
    ref_last = 1'b1;
    ref_rd   = '{32'h0, 32'h0};
  endtask

  initial begin
    req  = '{1'b0, 1'b0};
    we   = '{1'b0, 1'b0};
    addr = '{32'h0, 32'h0};
    wd   = '{32'h0, 32'h0};
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      mem[i]    <= ref_mem[i];
    end
    ref_rd   = '{32'h0, 32'h0};
    ref_last = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    repeat (10) begin
      @(negedge clk);
      check("rst_ctl", {59'b0, busy, p0_ack, p1_ack,
            mem_MemWrite, mem_MemRead}, 0);
      check("rst_addr", {32'b0, mem_Address}, 0);
      check("rst_wd", {32'b0, mem_WriteData}, 0);
      check("rst_rd", {p0_rdata, p1_rdata}, 0);
    end

    clr();
    add(0, 1'b1, 32'h4, 32'hAAAA_AAAA);
    add(0, 1'b0, 32'h4, 32'h0);
    run_scn("wr_rd");

    clr();
    add(0, 1'b0, 32'h0, 32'h0);
    add(1, 1'b0, 32'h4, 32'h0);
    run_scn("tie1");
    run_scn("tie2");

    clr();
    for (int i = 0; i < 3; i++)
      add(0, 1'b0, 32'h10 + i * 4, 32'h0);
    add(1, 1'b0, 32'h20, 32'h0);
    run_scn("prio");

    rst_test();

    clr();
    add(1, 1'b0, 32'h0, 32'h0);
    add(1, 1'b0, 32'h4, 32'h0);
    add(1, 1'b0, 32'h8, 32'h0);
    run_scn("b2b");

    for (int s = 0; s < 30; s++) begin
      clr();
      for (int p = 0; p < 2; p++) begin
        int n;
        n = $urandom_range(0, 3);
        toff[p] = $urandom_range(0, 2);
        for (int i = 0; i < n; i++)
          add(p, 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 15) * 4),
              $urandom);
      end
      run_scn($sformatf("rnd%0d", s));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
